// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared register-bank constants, requester indices and FSM state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int REG_DW = 32;
   localparam int REG_AW = 4;
   localparam int REG_N  = 16;

   localparam int WB_ALU  = 0;
   localparam int WB_LOAD = 1;
   localparam int WB_MUL  = 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker; first request at or after ptr wins
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            found_o
);

   // Two passes: requesters at/after ptr first, then the wrapped range below ptr.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_o = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found_o && req_i[j] && (j >= int'(ptr_i))) begin
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
            found_o  = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found_o && req_i[j]) begin
            gnt_o[j] = 1'b1;
            idx_o    = PW'(j);
            found_o  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module  : reg_write_arbiter
// Brief   : Round-robin arbiter driving the register bank's single write port
// Config  : ZERO_REG_LOCK_EN makes register 0 read-only
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_write_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int NREGS = REG_N,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 stall,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic [NREGS-1:0]     load,
   output logic [DW-1:0]        wdata,
   output logic [NREGS-1:0]     wr_pending,
   output logic                 busy
);

   localparam int PW = $clog2(NREQ);

   wr_state_t       state_q;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREGS-1:0] load_q, load_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic [NREQ-1:0] w_pick_gnt;
   logic [PW-1:0]   w_idx;
   logic            w_found;
   logic            w_xfer;
   logic            w_lock;
   logic            w_write;
   logic [AW-1:0]   w_addr;
   logic [DW-1:0]   w_data;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (w_pick_gnt),
      .idx_o   (w_idx),
      .found_o (w_found)
   );

   // Grant is masked during reset so nothing appears to handshake while clear is high.
   assign w_xfer = w_found && !stall && !clear;
   assign gnt    = w_xfer ? w_pick_gnt : '0;
   assign w_addr = req_addr[int'(w_idx)*AW +: AW];
   assign w_data = req_data[int'(w_idx)*DW +: DW];

`ifdef ZERO_REG_LOCK_EN
   assign w_lock = (w_addr == '0);
`else
   assign w_lock = 1'b0;
`endif

   assign w_write = w_xfer && !w_lock && (32'(w_addr) < 32'(NREGS));

   always_comb begin
      load_d  = '0;
      wdata_d = wdata_q;
      ptr_d   = ptr_q;
      for (int r = 0; r < NREGS; r++) begin
         load_d[r] = w_write && (32'(w_addr) == 32'(r));
      end
      if (w_xfer && !w_lock) begin
         wdata_d = w_data;
      end
      if (w_xfer) begin
         ptr_d = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         load_q  <= '0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         load_q  <= load_d;
         wdata_q <= wdata_d;
         case (state_q)
            IDLE:    if (w_xfer)  state_q <= WRITE;
            WRITE:   if (!w_xfer) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign load       = load_q;
   assign wr_pending = load_q;
   assign wdata      = wdata_q;
   assign busy       = (state_q == WRITE);

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module  : tb_reg_write_arbiter
// Brief   : Scoreboard bench for reg_write_arbiter (honours ZERO_REG_LOCK_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;
   import cpu_pkg::*;

   logic          clock = 1'b0;
   logic          clear;
   logic          stall;
   logic [2:0]    req;
   logic [11:0]   req_addr;
   logic [95:0]   req_data;
   logic [2:0]    gnt;
   logic [15:0]   load;
   logic [31:0]   wdata;
   logic [15:0]   wr_pending;
   logic          busy;

   typedef struct packed {
      logic [15:0] load;
      logic [31:0] wdata;
   } out_t;

   logic [2:0] exp_gnt_q[$];
   out_t       exp_out_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   reg_write_arbiter #(
      .NREQ  (3),
      .NREGS (16),
      .AW    (4),
      .DW    (32)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .stall      (stall),
      .req        (req),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .gnt        (gnt),
      .load       (load),
      .wdata      (wdata),
      .wr_pending (wr_pending),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_req(input int idx, input logic [3:0] addr, input logic [31:0] data);
      req_addr[idx*4 +: 4]   = addr;
      req_data[idx*32 +: 32] = data;
   endtask

   // Monitor: pops an expectation whenever the DUT grants or presents a write.
   always @(negedge clock) begin
      if (!clear) begin
         if (gnt !== 3'b000) begin
            if (exp_gnt_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_gnt: got %b expected none", gnt);
            end else begin
               check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
            end
         end
         if (busy) begin
            if (exp_out_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: got load %h wdata %h expected none", load, wdata);
            end else begin
               out_t e;
               e = exp_out_q.pop_front();
               check("load", 32'(load), 32'(e.load));
               check("wdata", wdata, e.wdata);
               check("wr_pending", 32'(wr_pending), 32'(e.load));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rr_data [3];
      rr_data[0] = 32'hA0A0_A0A0;
      rr_data[1] = 32'hA1A1_A1A1;
      rr_data[2] = 32'hA2A2_A2A2;

      clear = 1'b1;
      stall = 1'b0;
      req   = 3'b111;
      req_addr = '0;
      req_data = '0;
      set_req(WB_ALU,  4'd1, rr_data[0]);
      set_req(WB_LOAD, 4'd2, rr_data[1]);
      set_req(WB_MUL,  4'd3, rr_data[2]);

      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_load", 32'(load), 32'h0);
      check("rst_wdata", wdata, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);

      // Round-robin from ptr=0: grants 0,1,2,0,1,2 to addresses 1,2,3.
      for (int k = 0; k < 6; k++) begin
         exp_gnt_q.push_back(3'b001 << (k % 3));
         exp_out_q.push_back('{load: 16'h0001 << (k % 3 + 1), wdata: rr_data[k % 3]});
      end
      @(posedge clock);
      #1;
      clear = 1'b0;
      repeat (6) tick();
      req = 3'b000;
      tick();

      // Single write from the load unit; ptr=0 so search reaches requester 1.
      set_req(WB_LOAD, 4'd5, 32'hDEAD_BEEF);
      req = 3'b010;
      exp_gnt_q.push_back(3'b010);
      exp_out_q.push_back('{load: 16'h0020, wdata: 32'hDEAD_BEEF});
      tick();
      req = 3'b000;
      tick();
      @(negedge clock);
      check("busy_one_cycle", 32'(busy), 32'h0);

      // ptr=2: requester 0 wins via wrap, then stall holds off requester 2.
      set_req(WB_ALU, 4'd7, 32'h1111_1111);
      req = 3'b001;
      exp_gnt_q.push_back(3'b001);
      exp_out_q.push_back('{load: 16'h0080, wdata: 32'h1111_1111});
      tick();
      stall = 1'b1;
      set_req(WB_MUL, 4'd9, 32'h9999_9999);
      req = 3'b100;
      @(negedge clock);
      check("stall_gnt0", 32'(gnt), 32'h0);
      for (int k = 0; k < 2; k++) begin
         tick();
         @(negedge clock);
         check("stall_gnt", 32'(gnt), 32'h0);
         check("stall_load", 32'(load), 32'h0);
      end
      tick();
      stall = 1'b0;
      exp_gnt_q.push_back(3'b100);
      exp_out_q.push_back('{load: 16'h0200, wdata: 32'h9999_9999});
      tick();
      req = 3'b000;
      tick();

      // Address 0 write; ptr=0.
      set_req(WB_ALU, 4'd0, 32'h0000_0001);
      req = 3'b001;
      exp_gnt_q.push_back(3'b001);
`ifdef ZERO_REG_LOCK_EN
      exp_out_q.push_back('{load: 16'h0000, wdata: 32'h9999_9999});
`else
      exp_out_q.push_back('{load: 16'h0001, wdata: 32'h0000_0001});
`endif
      tick();
      req = 3'b000;
      repeat (2) tick();

      // Mid-write reset: ptr=1, transfer then clear before the load cycle ends.
      set_req(WB_LOAD, 4'd15, 32'hCAFE_F00D);
      req = 3'b010;
      exp_gnt_q.push_back(3'b010);
      tick();
      clear = 1'b1;
      req   = 3'b000;
      #1;
      check("midrst_load", 32'(load), 32'h0);
      check("midrst_wdata", wdata, 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_gnt", 32'(gnt), 32'h0);
      tick();
      clear = 1'b0;
      @(negedge clock);
      check("midrst_after_load", 32'(load), 32'h0);

      // After reset ptr=0: search 0,1,2 reaches requester 2.
      tick();
      set_req(WB_MUL, 4'd4, 32'h4444_4444);
      req = 3'b100;
      exp_gnt_q.push_back(3'b100);
      exp_out_q.push_back('{load: 16'h0010, wdata: 32'h4444_4444});
      tick();
      req = 3'b000;
      repeat (3) tick();

      check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'h0);
      check("out_queue_drained", 32'(exp_out_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Arbitrates register-write requests from several CPU datapath sources (ALU writeback, load unit, multiply unit) onto one shared write port of the 32-bit register bank. Each cycle it grants at most one requester in round-robin order, registers the winning address/data, and drives one-hot load strobes plus a broadcast data bus into the bank's `reg32bit` instances. It sits between the execute/writeback stages and the register bank, and is the only block that drives register `load` inputs.

## Interface
- `NREQ`, 3: number of write requesters (2..8)
- `NREGS`, 16: number of registers in the bank
- `AW`, 4: register address width, equal to clog2(`NREGS`)
- `DW`, 32: data width
- `clock`  in  1  single clock; all state updates on rising edge
- `clear`  in  1  asynchronous, active-high reset
- `stall`  in  1  pipeline freeze; no new grants while high
- `req`  in  NREQ  per-requester write request (valid)
- `req_addr`  in  NREQ*AW  packed target addresses; requester i occupies bits [i*AW +: AW]
- `req_data`  in  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW]
- `gnt`  out  NREQ  one-hot grant (ready); combinational from `req`, `stall` and the pointer
- `load`  out  NREGS  one-hot registered load strobes to the bank
- `wdata`  out  DW  registered write data, broadcast to all registers
- `wr_pending`  out  NREGS  equal to `load`; marks the register being written this cycle, for forwarding
- `busy`  out  1  high when the FSM is in WRITE

## Operation
- Handshake: transfer occurs at a rising edge when `req[i] && gnt[i]`. A requester holds `req`, `req_addr` and `req_data` stable until it is granted.
- Arbitration: round-robin pointer `ptr` (0..NREQ-1, reset 0). Search starts at `ptr`, increments, and wraps at NREQ-1 back to 0. The first requester found with `req` high is granted. After a grant to requester i, `ptr <= (i+1) mod NREQ`. With no grant, `ptr` holds.
- `gnt` is all zeros when `stall` is high or `req` is zero.
- FSM states: IDLE and WRITE.
  - IDLE -> WRITE on any transfer.
  - WRITE -> WRITE on another transfer (back-to-back writes allowed).
  - WRITE -> IDLE with no transfer.
  - `stall` blocks new grants only. A write already latched still completes.
- Output stage on transfer: `load <= onehot(req_addr[i])`, `wdata <= req_data[i]`. Otherwise `load <= 0` and `wdata` holds its value.
- Address >= `NREGS`: the request is granted (handshake completes) and `load` stays 0. The write is discarded.
- Reset values: `load`=0, `wdata`=0, `ptr`=0, state=IDLE, `busy`=0. `gnt` is 0 during reset. Asserting `clear` mid-write drops the latched write; `load` is forced to 0 immediately.

## Timing
- Transfer at edge N. `load`/`wdata` are valid in cycle N..N+1. The register captures at edge N+1, and the new value is visible on the register's `out` after N+1.
- One write per cycle maximum. Sustained throughput is 1 write/cycle.
- Starvation bound: a held request is granted within NREQ cycles of `stall` being low.
- `load` is high for exactly one cycle per transfer and is never more than one-hot.

## Configuration
- `ZERO_REG_LOCK_EN` defined: address 0 is read-only. A request to address 0 is granted and consumed, but `load[0]` is never asserted and `wdata` is not updated.
- Not defined: address 0 is an ordinary register.

## Structure
- Shared package `cpu_pkg` holds:
  - constants `REG_DW`=32, `REG_AW`=4, `REG_N`=16
  - requester index constants `WB_ALU`=0, `WB_LOAD`=1, `WB_MUL`=2
  - FSM state typedef `wr_state_t` {IDLE, WRITE}
- One sub-module: `rr_pick`. It is combinational and takes `req` and `ptr`, returning a one-hot grant and the winner index. The FSM, pointer and output registers stay in the top module.

## Test plan
- Reset: assert `clear` with `req`=3'b111. Required: `gnt`=0, `load`=0, `wdata`=0, `busy`=0; after release, first grant goes to requester 0.
- Single write: req[1]=1, addr=5, data=32'hDEADBEEF. Required: `gnt`=3'b010; next cycle `load`=16'h0020, `wdata`=DEADBEEF; `busy`=1 for one cycle.
- Round-robin: all three requesters held for 6 cycles. Required: grant order 0,1,2,0,1,2, with `load` a single pulse per cycle.
- Stall: `stall`=1 for 3 cycles while req[2]=1. Required: `gnt`=0 and `load`=0 after the in-flight write completes; grant to 2 on the first cycle after `stall` falls.
- Mid-write reset: transfer at edge N, `clear` pulsed in cycle N..N+1. Required: `load` drops to 0 immediately and the register is not written.
- Zero register with `ZERO_REG_LOCK_EN`: req addr=0, data=32'h1. Required: grant asserted, `load`=0. Without the macro, `load`=16'h0001.
